// File: rtl/qif_synapse_if.sv
// Bus bundle for qif_synapse: presynaptic spike, configuration write
// handshake and the synaptic current / activity outputs.
interface qif_synapse_if;
  logic              spike_in;
  logic              cfg_valid;
  logic [1:0]        cfg_addr;
  logic [7:0]        cfg_data;
  logic              cfg_ready;
  logic signed [7:0] I_syn;
  logic              busy;

  // Stimulus / controller side
  modport master (
    output spike_in, cfg_valid, cfg_addr, cfg_data,
    input  cfg_ready, I_syn, busy
  );

  // Synapse side
  modport slave (
    input  spike_in, cfg_valid, cfg_addr, cfg_data,
    output cfg_ready, I_syn, busy
  );
endinterface

// File: rtl/qif_synapse.sv
// qif_synapse: exponential-like decaying synaptic current driven by
// presynaptic spikes. Each accepted spike adds a signed weight (saturating);
// every DECAY_DIV cycles the current shrinks by I_syn >>> shift, with a
// minimum step of one LSB toward zero so the current always reaches 0.
// Weight, shift and enable are writable over a one-shot ready handshake.
module qif_synapse #(
  parameter int                DECAY_DIV      = 4,
  parameter logic signed [7:0] DEFAULT_WEIGHT = 8'sd16,
  parameter int                DEFAULT_SHIFT  = 2
) (
  input  logic          clk,
  input  logic          rst_n,   // active-high synchronous reset despite the name
  qif_synapse_if.slave  bus
);

  localparam logic [7:0] CNT_LAST  = 8'(DECAY_DIV - 1);
  localparam logic [2:0] SHIFT_RST = 3'(DEFAULT_SHIFT);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic signed [7:0] isyn_q, isyn_d;
  logic signed [7:0] weight_q, weight_d;
  logic [2:0]        shift_q, shift_d;
  logic              en_q, en_d;
  logic              rdy_q, rdy_d;

  logic              tick;
  logic              spike_acc;
  logic              cfg_acc;
  logic signed [7:0] base;
  logic signed [8:0] sum;

  // One decay step: subtract v >>> sh, but never less than one LSB toward zero.
  function automatic logic signed [7:0] decay_step(input logic signed [7:0] v,
                                                   input logic [2:0] sh);
    logic signed [7:0] d;
    d = v >>> sh;
    if (d == 8'sd0 && v != 8'sd0)
      d = (v < 8'sd0) ? -8'sd1 : 8'sd1;
    return v - d;
  endfunction

  // Clamp a 9-bit signed sum into the 8-bit signed range.
  function automatic logic signed [7:0] sat9(input logic signed [8:0] s);
    if (s > 9'sd127)
      return 8'sd127;
    else if (s < -9'sd128)
      return -8'sd128;
    else
      return s[7:0];
  endfunction

  // Next-state: decay tick, spike accumulation, state/counter and config writes.
  always_comb begin
    tick      = (state_q == ACTIVE) && (cnt_q == CNT_LAST);
    base      = tick ? decay_step(isyn_q, shift_q) : isyn_q;
    spike_acc = bus.spike_in && en_q;
    sum       = $signed({base[7], base}) + $signed({weight_q[7], weight_q});
    isyn_d    = spike_acc ? sat9(sum) : base;
    state_d   = (isyn_d != 8'sd0) ? ACTIVE : IDLE;

    cnt_d = 8'd0;
    if (state_q == ACTIVE && state_d == ACTIVE)
      cnt_d = (cnt_q == CNT_LAST) ? 8'd0 : cnt_q + 8'd1;

    cfg_acc  = bus.cfg_valid && rdy_q;
    rdy_d    = !cfg_acc;
    weight_d = weight_q;
    shift_d  = shift_q;
    en_d     = en_q;
    if (cfg_acc) begin
      case (bus.cfg_addr)
        2'd0:    weight_d = bus.cfg_data;
        2'd1:    shift_d  = (bus.cfg_data[2:0] == 3'd0) ? 3'd1 : bus.cfg_data[2:0];
        2'd2:    en_d     = bus.cfg_data[0];
        default: ;
      endcase
    end
  end

  // State register; reset wins over any simultaneous spike or config write.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      isyn_q   <= 8'sd0;
      weight_q <= DEFAULT_WEIGHT;
      shift_q  <= SHIFT_RST;
      en_q     <= 1'b1;
      rdy_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      isyn_q   <= isyn_d;
      weight_q <= weight_d;
      shift_q  <= shift_d;
      en_q     <= en_d;
      rdy_q    <= rdy_d;
    end
  end

  assign bus.I_syn     = isyn_q;
  assign bus.busy      = (state_q == ACTIVE);
  assign bus.cfg_ready = rdy_q;

endmodule

// File: tb/tb_qif_synapse.sv
// Directed bench for qif_synapse: a table of per-cycle vectors
// {reset, spike, config write, expected I_syn/busy/cfg_ready} plus a
// hand-written reset-override and zero-sum sequence.
module tb_qif_synapse;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  qif_synapse_if bif ();

  qif_synapse #(
    .DECAY_DIV      (4),
    .DEFAULT_WEIGHT (8'sd16),
    .DEFAULT_SHIFT  (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              rst;
    logic              spk;
    logic              cv;
    logic [1:0]        ca;
    logic [7:0]        cd;
    logic signed [7:0] isyn;
    logic              busy;
    logic              rdy;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic spk, input logic cv,
                              input logic [1:0] ca, input logic [7:0] cd,
                              input logic signed [7:0] isyn, input logic busy,
                              input logic rdy);
    vec_t v;
    v.rst = rst; v.spk = spk; v.cv = cv; v.ca = ca; v.cd = cd;
    v.isyn = isyn; v.busy = busy; v.rdy = rdy;
    vq.push_back(v);
  endfunction

  // n idle cycles with the same expected outputs
  function automatic void idle(input int n, input logic signed [7:0] isyn,
                               input logic busy);
    for (int k = 0; k < n; k++) add(0, 0, 0, 2'd0, 8'h00, isyn, busy, 1'b1);
  endfunction

  task automatic drive(input logic rst, input logic spk, input logic cv,
                       input logic [1:0] ca, input logic [7:0] cd);
    @(negedge clk);
    rst_n         = rst;
    bif.spike_in  = spk;
    bif.cfg_valid = cv;
    bif.cfg_addr  = ca;
    bif.cfg_data  = cd;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic signed [7:0] isyn,
                       input logic busy, input logic rdy);
    total++;
    if (bif.I_syn !== isyn) begin
      bad++;
      $display("FAIL %s I_syn: got %0d want %0d", tag, bif.I_syn, isyn);
    end
    total++;
    if (bif.busy !== busy) begin
      bad++;
      $display("FAIL %s busy: got %0b want %0b", tag, bif.busy, busy);
    end
    total++;
    if (bif.cfg_ready !== rdy) begin
      bad++;
      $display("FAIL %s cfg_ready: got %0b want %0b", tag, bif.cfg_ready, rdy);
    end
  endtask

  initial begin
    rst_n = 1'b1; bif.spike_in = 1'b0; bif.cfg_valid = 1'b0;
    bif.cfg_addr = 2'd0; bif.cfg_data = 8'h00;

    // reset, idle, default-weight spike
    add(1, 0, 0, 2'd0, 8'h00,   0, 0, 1);
    idle(1, 0, 0);
    add(0, 1, 0, 2'd0, 8'h00,  16, 1, 1);

    // weight=40, ready held low for one cycle even with valid held, then decay
    add(1, 0, 0, 2'd0, 8'h00,   0, 0, 1);
    add(0, 0, 1, 2'd0, 8'd40,   0, 0, 0);
    add(0, 0, 1, 2'd0, 8'd99,   0, 0, 1);
    add(0, 1, 0, 2'd0, 8'h00,  40, 1, 1);
    idle(3, 40, 1); idle(1, 30, 1);
    idle(3, 30, 1); idle(1, 23, 1);
    idle(3, 23, 1); idle(1, 18, 1);
    idle(3, 18, 1); idle(1, 14, 1);

    // positive saturation
    add(1, 0, 0, 2'd0, 8'h00,   0, 0, 1);
    add(0, 0, 1, 2'd0, 8'd100,  0, 0, 0);
    idle(1, 0, 0);
    add(0, 1, 0, 2'd0, 8'h00, 100, 1, 1);
    add(0, 1, 0, 2'd0, 8'h00, 127, 1, 1);

    // negative saturation: -100 then weight -128
    add(1, 0, 0, 2'd0, 8'h00,   0, 0, 1);
    add(0, 0, 1, 2'd0, 8'h9C,   0, 0, 0);
    idle(1, 0, 0);
    add(0, 1, 0, 2'd0, 8'h00, -100, 1, 1);
    add(0, 0, 1, 2'd0, 8'h80, -100, 1, 0);
    add(0, 1, 0, 2'd0, 8'h00, -128, 1, 1);

    // weight -3 decays -3,-2,-1,0 with minimum step
    add(1, 0, 0, 2'd0, 8'h00,   0, 0, 1);
    add(0, 0, 1, 2'd0, 8'hFD,   0, 0, 0);
    idle(1, 0, 0);
    add(0, 1, 0, 2'd0, 8'h00,  -3, 1, 1);
    idle(3, -3, 1); idle(1, -2, 1);
    idle(3, -2, 1); idle(1, -1, 1);
    idle(3, -1, 1); idle(1,  0, 0);
    idle(1, 0, 0);

    // disable in same cycle as spike: old enable applies; later spikes ignored, decay runs
    add(0, 1, 1, 2'd2, 8'h00,  -3, 1, 0);
    idle(1, -3, 1);
    add(0, 1, 0, 2'd0, 8'h00,  -3, 1, 1);
    add(0, 1, 0, 2'd0, 8'h00,  -3, 1, 1);
    add(0, 1, 0, 2'd0, 8'h00,  -2, 1, 1);

    // shift written as 0 stores 1; reserved address write has no effect
    add(1, 0, 0, 2'd0, 8'h00,   0, 0, 1);
    add(0, 0, 1, 2'd1, 8'h00,   0, 0, 0);
    idle(1, 0, 0);
    add(0, 1, 0, 2'd0, 8'h00,  16, 1, 1);
    add(0, 0, 1, 2'd3, 8'hFF,  16, 1, 0);
    idle(2, 16, 1);
    idle(1, 8, 1);

    // spike on the tick edge adds to the decayed value: 30 + 40
    add(1, 0, 0, 2'd0, 8'h00,   0, 0, 1);
    add(0, 0, 1, 2'd0, 8'd40,   0, 0, 0);
    idle(1, 0, 0);
    add(0, 1, 0, 2'd0, 8'h00,  40, 1, 1);
    idle(3, 40, 1);
    add(0, 1, 0, 2'd0, 8'h00,  70, 1, 1);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].spk, vq[i].cv, vq[i].ca, vq[i].cd);
      check($sformatf("vec%0d", i), vq[i].isyn, vq[i].busy, vq[i].rdy);
    end

    // reset while ACTIVE at 70 with spike and config write pending
    drive(1, 1, 1, 2'd0, 8'd5);
    check("rst_override", 0, 0, 1);
    drive(0, 1, 0, 2'd0, 8'h00);
    check("weight_restored", 16, 1, 1);
    // spike sum exactly zero returns to IDLE
    drive(0, 0, 1, 2'd0, 8'hF0);
    check("cfg_neg16", 16, 1, 0);
    drive(0, 0, 0, 2'd0, 8'h00);
    check("hold16", 16, 1, 1);
    drive(0, 1, 0, 2'd0, 8'h00);
    check("zero_sum", 0, 0, 1);
    drive(0, 0, 0, 2'd0, 8'h00);
    check("stay_idle", 0, 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
